clock_divider_bank: RTL and testbench
=====================================

Name: clock_divider_bank

Overview:
Parametrised bank of independent programmable clock dividers. It is the successor to the fixed single-ratio dividers in the clock utilities. Each channel generates a 50% duty divided clock with built-in one-cycle rise/fall strobes, so consumers need no separate edge detector. Channels support glitch-free start/stop, runtime ratio change and a global phase-align (sync) pulse. The bank sits between the system clock and the e-paper source/gate timing logic.

Parameters:
NUM_CH, 4, number of divider channels
CNT_W, 16, width of divide value and per-channel counter
DEFAULT_DIV, 11, divide value loaded on reset (half period = DEFAULT_DIV+1 clocks)

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
en  in  NUM_CH  per-channel run request (level)
sync  in  1  one-cycle phase-align pulse for all channels
wr_en  in  1  divide-value write strobe
wr_ch  in  $clog2(NUM_CH) (min 1)  channel selected by write
wr_data  in  CNT_W  new divide value
clk_out  out  NUM_CH  divided clocks, registered
rise  out  NUM_CH  one-cycle strobe, high in first cycle clk_out[i] is 1
fall  out  NUM_CH  one-cycle strobe, high in first cycle clk_out[i] is 0
busy  out  NUM_CH  1 when channel state is RUN or STOPPING

Behaviour:
- Reset: clk_out=0, rise=0, fall=0, busy=0, all counters 0, all states IDLE, pending and active divide = DEFAULT_DIV.
- Per channel: state IDLE/RUN/STOPPING, counter, div_pending, div_active.
- Write: wr_en with wr_ch<NUM_CH sets div_pending[wr_ch]=wr_data. wr_ch>=NUM_CH is ignored. div_active is unchanged until the next toggle, start or sync. No partial half-periods.
- Counting (RUN/STOPPING): when counter==div_active, the cycle is a toggle. On a toggle: counter<=0, clk_out inverts, div_active<=div_pending. Otherwise counter increments. Half period = div_active+1 clocks; div=0 gives clock/2.
- rise/fall are registered alongside clk_out. Exactly one strobe per toggle.
- IDLE->RUN: en[i]=1 sampled. Counter restarts at 0, div_active<=div_pending, clk_out stays 0. First rise occurs div+1 clocks after the sampling edge.
- RUN, en[i]=0, clk_out=0: go IDLE immediately, counter 0, no strobe.
- RUN, en[i]=0, clk_out=1: go STOPPING. The high phase completes normally. At the falling toggle, fall pulses and the channel goes IDLE. No runt pulse is ever produced.
- STOPPING, en[i]=1 again: return to RUN with no disturbance to counter or output.
- sync=1 (priority over counting):
  - Every RUN channel: counter<=0, clk_out<=0, div_active<=div_pending. If clk_out was 1, fall pulses.
  - STOPPING channels: go IDLE with the same forced low and fall strobe.
  - IDLE channels are unaffected.
- sync and wr_en in the same cycle: the written channel's div_active takes wr_data (write bypass).
- en changes are honoured in the same cycle as sync. Evaluation order: sync first, then start/stop.
- reset has priority over everything. Mid-period reset returns the channel to IDLE low with no strobe.

Optional Feature:
- Macro: CLKDIV_BURST_EN.
- Defined: adds parameter BURST_W (default 10), input burst_len [BURST_W] and output done [NUM_CH].
  - In RUN, the channel counts rising edges. When the count reaches burst_len, the channel enters STOPPING automatically, and done[i] pulses one cycle on the falling toggle that parks it.
  - The channel then stays IDLE until en[i] is deasserted and reasserted.
  - burst_len=0 means unlimited. The count clears on start, sync and reset.
- Undefined: no extra ports; channels run continuously while enabled.

Test Plan:
- Reset, then en[0]=1 with DEFAULT_DIV=11 -> first rise[0] 12 clocks after the en edge; period 24; rise/fall alternate every 12 clocks.
- Write ch1 div=2, en[1]=1 -> period 6. Write div=0 mid-high-phase -> the current half period finishes at 3 clocks, then period 2 thereafter.
- Deassert en[0] while clk_out[0]=1 -> high phase completes full length, fall pulses once, busy[0]=0 next cycle. Deassert while low -> immediate park, no strobe.
- Ch0 div=3, ch2 div=5 running out of phase; sync pulse -> both forced low (fall only on the high one), then ch0 rises 4 clocks and ch2 rises 6 clocks after sync.
- Assert reset mid-high-phase -> next cycle all outputs 0 and div_active=11. wr_ch=NUM_CH write -> no channel changes.
- CLKDIV_BURST_EN, burst_len=3, div=1 -> exactly 3 rises, done pulse on the 3rd fall, channel stays low with en still high.

Source files
------------

// File: rtl/clock_divider_bank.sv
// clock_divider_bank: bank of independent programmable 50% duty clock dividers with registered rise/fall strobes.
// Define CLKDIV_BURST_EN to add burst mode (BURST_W, burst_len, done): a channel parks itself after burst_len rising edges.
module clock_divider_bank #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 11
`ifdef CLKDIV_BURST_EN
  ,
  parameter int BURST_W     = 10
`endif
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic [NUM_CH-1:0]                               en,
  input  logic                                            sync,
  input  logic                                            wr_en,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_ch,
  input  logic [CNT_W-1:0]                                wr_data,
  output logic [NUM_CH-1:0]                               clk_out,
  output logic [NUM_CH-1:0]                               rise,
  output logic [NUM_CH-1:0]                               fall,
  output logic [NUM_CH-1:0]                               busy
`ifdef CLKDIV_BURST_EN
  ,
  input  logic [BURST_W-1:0]                              burst_len,
  output logic [NUM_CH-1:0]                               done
`endif
);

  localparam int              CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  // state | meaning: IDLE parked low | RUN toggling | STOPPING finishing the current high phase
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  state_t            state_q    [NUM_CH];
  state_t            state_d    [NUM_CH];
  logic [CNT_W-1:0]  cnt_q      [NUM_CH];
  logic [CNT_W-1:0]  cnt_d      [NUM_CH];
  logic [CNT_W-1:0]  div_pend_q [NUM_CH];
  logic [CNT_W-1:0]  div_pend_d [NUM_CH];
  logic [CNT_W-1:0]  div_act_q  [NUM_CH];
  logic [CNT_W-1:0]  div_act_d  [NUM_CH];
  logic [CNT_W-1:0]  div_nxt    [NUM_CH];
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] rise_q, rise_d;
  logic [NUM_CH-1:0] fall_q, fall_d;
  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] tgl;
  logic [NUM_CH-1:0] stop_req;
  logic [NUM_CH-1:0] start_ok;

`ifdef CLKDIV_BURST_EN
  logic [BURST_W-1:0] bcnt_q [NUM_CH];
  logic [BURST_W-1:0] bcnt_d [NUM_CH];
  logic [NUM_CH-1:0]  bstop_q, bstop_d;
  logic [NUM_CH-1:0]  lock_q, lock_d;
  logic [NUM_CH-1:0]  done_q, done_d;
  logic [NUM_CH-1:0]  reach;
`endif

  // A write landing in the same cycle as a toggle, start or sync takes effect immediately.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i]  = wr_en && (wr_ch == CH_W'(i));
      div_nxt[i] = wr_hit[i] ? wr_data : div_pend_q[i];
      tgl[i]     = (cnt_q[i] == div_act_q[i]);
`ifdef CLKDIV_BURST_EN
      reach[i]    = (burst_len != '0) && ((bcnt_q[i] + BURST_W'(1)) == burst_len);
      stop_req[i] = !en[i] || bstop_q[i];
      start_ok[i] = !lock_q[i];
`else
      stop_req[i] = !en[i];
      start_ok[i] = 1'b1;
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]    = state_q[i];
      cnt_d[i]      = cnt_q[i];
      div_act_d[i]  = div_act_q[i];
      div_pend_d[i] = wr_hit[i] ? wr_data : div_pend_q[i];
      clk_d[i]      = clk_q[i];
      rise_d[i]     = 1'b0;
      fall_d[i]     = 1'b0;
`ifdef CLKDIV_BURST_EN
      bcnt_d[i]     = bcnt_q[i];
      bstop_d[i]    = bstop_q[i];
      lock_d[i]     = lock_q[i] && en[i];
      done_d[i]     = 1'b0;
`endif
      if (sync && (state_q[i] != ST_IDLE)) begin
        // Forced low realignment; en is then applied to the realigned channel.
        cnt_d[i]     = '0;
        clk_d[i]     = 1'b0;
        fall_d[i]    = clk_q[i];
        div_act_d[i] = div_nxt[i];
        state_d[i]   = (en[i] && start_ok[i]) ? ST_RUN : ST_IDLE;
`ifdef CLKDIV_BURST_EN
        bcnt_d[i]    = '0;
        bstop_d[i]   = 1'b0;
`endif
      end else begin
        unique case (state_q[i])
          ST_IDLE: begin
            if (en[i] && start_ok[i]) begin
              state_d[i]   = ST_RUN;
              cnt_d[i]     = '0;
              div_act_d[i] = div_nxt[i];
`ifdef CLKDIV_BURST_EN
              bcnt_d[i]    = '0;
`endif
            end
          end
          ST_RUN, ST_STOPPING: begin
            if ((state_q[i] == ST_RUN) && !en[i] && !clk_q[i]) begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = '0;
            end else if (tgl[i]) begin
              cnt_d[i]     = '0;
              clk_d[i]     = ~clk_q[i];
              rise_d[i]    = ~clk_q[i];
              fall_d[i]    = clk_q[i];
              div_act_d[i] = div_nxt[i];
              if (clk_q[i]) begin
                state_d[i] = stop_req[i] ? ST_IDLE : ST_RUN;
`ifdef CLKDIV_BURST_EN
                if (bstop_q[i]) begin
                  done_d[i]  = 1'b1;
                  lock_d[i]  = 1'b1;
                  bstop_d[i] = 1'b0;
                end
`endif
              end else begin
                state_d[i] = ST_RUN;
`ifdef CLKDIV_BURST_EN
                bcnt_d[i] = bcnt_q[i] + BURST_W'(1);
                if (reach[i]) begin
                  bstop_d[i] = 1'b1;
                  state_d[i] = ST_STOPPING;
                end
`endif
              end
            end else begin
              cnt_d[i]   = cnt_q[i] + CNT_W'(1);
              state_d[i] = stop_req[i] ? ST_STOPPING : ST_RUN;
            end
          end
          default: state_d[i] = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]    <= ST_IDLE;
        cnt_q[i]      <= '0;
        div_pend_q[i] <= DEF_DIV;
        div_act_q[i]  <= DEF_DIV;
`ifdef CLKDIV_BURST_EN
        bcnt_q[i]     <= '0;
`endif
      end
      clk_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
`ifdef CLKDIV_BURST_EN
      bstop_q <= '0;
      lock_q  <= '0;
      done_q  <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]    <= state_d[i];
        cnt_q[i]      <= cnt_d[i];
        div_pend_q[i] <= div_pend_d[i];
        div_act_q[i]  <= div_act_d[i];
`ifdef CLKDIV_BURST_EN
        bcnt_q[i]     <= bcnt_d[i];
`endif
      end
      clk_q  <= clk_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
`ifdef CLKDIV_BURST_EN
      bstop_q <= bstop_d;
      lock_q  <= lock_d;
      done_q  <= done_d;
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i] = (state_q[i] != ST_IDLE);
    end
  end

  assign clk_out = clk_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
`ifdef CLKDIV_BURST_EN
  assign done    = done_q;
`endif

endmodule

// File: tb/tb_clock_divider_bank.sv
// Bench for clock_divider_bank: directed vectors and sequences plus randomized traffic against a timestamp-based model.
module tb_clock_divider_bank;
  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int DEF = 11;

  logic           clock = 1'b0;
  logic           reset;
  logic [NCH-1:0] en;
  logic           sync;
  logic           wr_en;
  logic [1:0]     wr_ch;
  logic [CW-1:0]  wr_data;
  logic [NCH-1:0] clk_out, rise, fall, busy;

  clock_divider_bank #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DEF)) dut (
    .clock   (clock),
    .reset   (reset),
    .en      (en),
    .sync    (sync),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_data (wr_data),
    .clk_out (clk_out),
    .rise    (rise),
    .fall    (fall),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: each active channel remembers the absolute cycle of its next toggle.
  int unsigned    cyc = 0;
  int             m_mode [NCH];
  int unsigned    m_tn   [NCH];
  int unsigned    m_pend [NCH];
  int unsigned    m_dn;
  logic [NCH-1:0] m_lvl  = '0;
  logic [NCH-1:0] m_rise = '0;
  logic [NCH-1:0] m_fall = '0;
  logic [NCH-1:0] m_busy = '0;

  always @(posedge clock) begin
    cyc = cyc + 1;
    for (int i = 0; i < NCH; i++) begin
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      m_dn = (wr_en && int'(wr_ch) == i) ? int'(wr_data) : m_pend[i];
      if (reset) begin
        m_mode[i] = 0;
        m_lvl[i]  = 1'b0;
        m_pend[i] = DEF;
      end else begin
        if (sync && m_mode[i] != 0) begin
          m_fall[i] = m_lvl[i];
          m_lvl[i]  = 1'b0;
          m_tn[i]   = cyc + m_dn + 1;
          m_mode[i] = en[i] ? 1 : 0;
        end else if (m_mode[i] == 0) begin
          if (en[i]) begin
            m_mode[i] = 1;
            m_tn[i]   = cyc + m_dn + 1;
          end
        end else if (!en[i] && !m_lvl[i]) begin
          m_mode[i] = 0;
        end else if (cyc == m_tn[i]) begin
          m_lvl[i]  = !m_lvl[i];
          m_rise[i] = m_lvl[i];
          m_fall[i] = !m_lvl[i];
          m_tn[i]   = cyc + m_dn + 1;
          m_mode[i] = en[i] ? 1 : 0;
        end else begin
          m_mode[i] = en[i] ? 1 : 2;
        end
        if (wr_en && int'(wr_ch) == i) m_pend[i] = int'(wr_data);
      end
      m_busy[i] = (m_mode[i] != 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    check("model_clk_out", 32'(clk_out), 32'(m_lvl));
    check("model_rise",    32'(rise),    32'(m_rise));
    check("model_fall",    32'(fall),    32'(m_fall));
    check("model_busy",    32'(busy),    32'(m_busy));
  endtask

  task automatic wr(input int ch, input int data);
    wr_en   = 1'b1;
    wr_ch   = 2'(ch);
    wr_data = CW'(data);
    tick();
    wr_en   = 1'b0;
  endtask

  // Returns the number of ticks until the strobe, or -1 if the bound expires.
  task automatic wait_edge(input int ch, input bit want_rise, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if ((want_rise ? rise[ch] : fall[ch]) == 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int ch, input int limit);
    for (int k = 0; k < limit; k++) begin
      if (!busy[ch]) break;
      tick();
    end
    check("idle_timeout", 32'(busy[ch]), 32'd0);
  endtask

  typedef struct {
    int ch;
    int div;
    int first;
    int half;
  } vec_t;

  vec_t tbl [5];
  int n, r0, r2;

  initial begin
    tbl[0] = '{ch: 0, div: 11, first: 12, half: 12};
    tbl[1] = '{ch: 1, div: 2,  first: 3,  half: 3};
    tbl[2] = '{ch: 2, div: 0,  first: 1,  half: 1};
    tbl[3] = '{ch: 1, div: 5,  first: 6,  half: 6};
    tbl[4] = '{ch: 2, div: 3,  first: 4,  half: 4};

    reset = 1'b1; en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
    tick();
    tick();
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_rise",    32'(rise),    32'd0);
    check("rst_fall",    32'(fall),    32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    reset = 1'b0;
    tick();

    // Table: divide value -> first rise latency and half period.
    for (int t = 0; t < 5; t++) begin
      if (tbl[t].div != DEF) wr(tbl[t].ch, tbl[t].div);
      en[tbl[t].ch] = 1'b1;
      tick();
      wait_edge(tbl[t].ch, 1'b1, 100, n);
      check("tbl_first_rise", 32'(n), 32'(tbl[t].first));
      wait_edge(tbl[t].ch, 1'b0, 100, n);
      check("tbl_high_len", 32'(n), 32'(tbl[t].half));
      wait_edge(tbl[t].ch, 1'b1, 100, n);
      check("tbl_low_len", 32'(n), 32'(tbl[t].half));
      en[tbl[t].ch] = 1'b0;
      wait_idle(tbl[t].ch, 64);
    end

    // Ratio change mid-high-phase: current half period keeps its length.
    wr(1, 2);
    en[1] = 1'b1;
    tick();
    wait_edge(1, 1'b1, 20, n);
    check("div2_first_rise", 32'(n), 32'd3);
    tick();
    wr(1, 0);
    wait_edge(1, 1'b0, 20, n);
    check("div_change_tail", 32'(n + 2), 32'd3);
    wait_edge(1, 1'b1, 20, n);
    check("div0_low", 32'(n), 32'd1);
    wait_edge(1, 1'b0, 20, n);
    check("div0_high", 32'(n), 32'd1);
    en[1] = 1'b0;
    tick();
    check("div0_park_busy", 32'(busy[1]), 32'd0);

    // Stop while high: full high phase then a single fall.
    en[0] = 1'b1;
    tick();
    wait_edge(0, 1'b1, 30, n);
    check("stop_hi_rise", 32'(n), 32'd12);
    tick();
    tick();
    en[0] = 1'b0;
    wait_edge(0, 1'b0, 30, n);
    check("stop_hi_len", 32'(n + 2), 32'd12);
    check("stop_hi_busy", 32'(busy[0]), 32'd0);
    tick();
    check("stop_hi_one_fall", 32'(fall[0]), 32'd0);
    repeat (30) tick();
    check("stop_hi_parked", 32'(clk_out[0]), 32'd0);

    // Stop while low: immediate park without strobe.
    en[0] = 1'b1;
    tick();
    wait_edge(0, 1'b1, 30, n);
    wait_edge(0, 1'b0, 30, n);
    tick();
    tick();
    en[0] = 1'b0;
    tick();
    check("stop_lo_busy", 32'(busy[0]), 32'd0);
    check("stop_lo_strobe", 32'({rise[0], fall[0], clk_out[0]}), 32'd0);

    // Sync: ch0 div 3 (low at sync), ch2 div 5 (high at sync).
    wr(0, 3);
    wr(2, 5);
    en[0] = 1'b1;
    tick();
    tick();
    tick();
    en[2] = 1'b1;
    tick();
    repeat (6) tick();
    check("pre_sync_ch0", 32'(clk_out[0]), 32'd0);
    check("pre_sync_ch2", 32'(clk_out[2]), 32'd1);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_low", 32'(clk_out & 3'b101), 32'd0);
    check("sync_fall", 32'(fall & 3'b101), 32'b100);
    r0 = -1;
    r2 = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (rise[0] && r0 < 0) r0 = k;
      if (rise[2] && r2 < 0) r2 = k;
    end
    check("sync_ch0_rise", 32'(r0), 32'd4);
    check("sync_ch2_rise", 32'(r2), 32'd6);
    en = '0;
    repeat (20) tick();

    // Reset mid-high-phase restores defaults.
    en[0] = 1'b1;
    tick();
    wait_edge(0, 1'b1, 20, n);
    check("prerst_rise", 32'(n), 32'd4);
    tick();
    reset = 1'b1;
    tick();
    check("midrst_clk_out", 32'(clk_out), 32'd0);
    check("midrst_strobes", 32'({rise, fall}), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    en[1] = 1'b1;
    tick();
    wait_edge(0, 1'b1, 30, n);
    check("postrst_div_ch0", 32'(n), 32'd12);
    check("postrst_div_ch1", 32'(rise[1]), 32'd1);
    en = '0;
    repeat (30) tick();

    // Out-of-range channel write is ignored.
    wr(3, 1);
    en = '1;
    tick();
    wait_edge(0, 1'b1, 30, n);
    check("oor_first_rise", 32'(n), 32'd12);
    check("oor_all_rise", 32'(rise), 32'b111);
    en = '0;
    repeat (30) tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      reset   = ($urandom_range(0, 299) == 0);
      sync    = ($urandom_range(0, 39) == 0);
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_ch   = 2'($urandom_range(0, 3));
      wr_data = CW'($urandom_range(0, 4));
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 24) == 0) en[i] = ~en[i];
      end
      tick();
    end
    reset = 1'b0; sync = 1'b0; wr_en = 1'b0; en = '0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
